// File: rtl/weight_loader_pkg.sv
// Shared types for the accelerator weight path: word type and loader state encoding.
// Pure declarations, so there is no latency and no backpressure.
package accel_pkg;
    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        LD_FILL,
        LD_DRAIN,
        LD_PENDING
    } ld_state_t;

    // Counters always get at least one bit, even for a single row or column.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/weight_loader_if.sv
// AXI4-Stream weight channel: the producer drives data, last and valid; the loader drives ready.
// Pure wiring, so there is no latency; ready carries the backpressure.
interface weight_loader_if;
    import accel_pkg::*;

    word_t tdata;
    logic  tlast;
    logic  tvalid;
    logic  tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/weight_loader.sv
// Streams a ROWS x COLS matrix into a shadow buffer and commits it atomically when hold is low.
// Commit happens one edge after the last beat; tready is low while a commit waits for hold.
module weight_loader
    import accel_pkg::*;
#(
    parameter int ROWS = 3,
    parameter int COLS = 4
) (
    input  logic            clk,
    input  logic            rst,
    weight_loader_if.slave  weight_axis,
    input  logic            hold,
    output word_t           weights [ROWS][COLS],
    output logic            weights_valid,
    output logic            commit_pulse,
    output logic            load_error
);
    localparam int ROW_W = cnt_w(ROWS);
    localparam int COL_W = cnt_w(COLS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    ld_state_t        r_state;
    ld_state_t        w_state_nxt;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    word_t            r_shadow [ROWS][COLS];
    word_t            r_active [ROWS][COLS];
    logic             r_valid;
    logic             r_commit;
    logic             r_error;

    logic w_tready;
    logic w_beat;
    logic w_last_idx;
    logic w_wr_shadow;
    logic w_adv;
    logic w_clr;
    logic w_commit;
    logic w_error;

    // Ready depends on state alone; gating with rst keeps it low throughout reset.
    assign w_tready   = rst & ((r_state == LD_FILL) | (r_state == LD_DRAIN));
    assign w_beat     = weight_axis.tvalid & w_tready;
    assign w_last_idx = (r_row == LAST_ROW) && (r_col == LAST_COL);

    always_comb begin
        w_state_nxt = r_state;
        w_wr_shadow = 1'b0;
        w_adv       = 1'b0;
        w_clr       = 1'b0;
        w_commit    = 1'b0;
        w_error     = 1'b0;
        case (r_state)
            LD_FILL: begin
                if (w_beat) begin
                    w_wr_shadow = 1'b1;
                    if (w_last_idx) begin
                        w_clr = 1'b1;
                        if (weight_axis.tlast) begin
                            w_state_nxt = LD_PENDING;
                        end else begin
                            w_state_nxt = LD_DRAIN;
                            w_error     = 1'b1;
                        end
                    end else if (weight_axis.tlast) begin
                        w_clr   = 1'b1;
                        w_error = 1'b1;
                    end else begin
                        w_adv = 1'b1;
                    end
                end
            end
            LD_DRAIN: begin
                if (w_beat && weight_axis.tlast) begin
                    w_state_nxt = LD_FILL;
                    w_clr       = 1'b1;
                end
            end
            LD_PENDING: begin
                if (!hold) begin
                    w_commit    = 1'b1;
                    w_state_nxt = LD_FILL;
                    w_clr       = 1'b1;
                end
            end
            default: begin
                w_state_nxt = LD_FILL;
                w_clr       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= LD_FILL;
            r_row    <= '0;
            r_col    <= '0;
            r_valid  <= 1'b0;
            r_commit <= 1'b0;
            r_error  <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    r_shadow[r][c] <= '0;
                    r_active[r][c] <= '0;
                end
            end
        end else begin
            r_state  <= w_state_nxt;
            r_commit <= w_commit;
            r_error  <= w_error;
            if (w_wr_shadow) begin
                r_shadow[r_row][r_col] <= weight_axis.tdata;
            end
            if (w_clr) begin
                r_row <= '0;
                r_col <= '0;
            end else if (w_adv) begin
                if (r_col == LAST_COL) begin
                    r_col <= '0;
                    r_row <= r_row + ROW_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end
            // Whole-array copy: the consumer never sees a half-updated matrix.
            if (w_commit) begin
                r_active <= r_shadow;
                r_valid  <= 1'b1;
            end
        end
    end

    assign weight_axis.tready = w_tready;
    assign weights            = r_active;
    assign weights_valid      = r_valid;
    assign commit_pulse       = r_commit;
    assign load_error         = r_error;
endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: queue-based frame model checked every cycle, plus pinned literal checks.
module tb_weight_loader;
    import accel_pkg::*;

    localparam int ROWS = 3;
    localparam int COLS = 4;
    localparam int N    = ROWS * COLS;

    logic  clk  = 1'b0;
    logic  rst  = 1'b0;
    logic  hold = 1'b0;
    word_t weights [ROWS][COLS];
    logic  weights_valid;
    logic  commit_pulse;
    logic  load_error;

    weight_loader_if u_axis ();

    weight_loader #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk           (clk),
        .rst           (rst),
        .weight_axis   (u_axis),
        .hold          (hold),
        .weights       (weights),
        .weights_valid (weights_valid),
        .commit_pulse  (commit_pulse),
        .load_error    (load_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    bit rand_hold = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 0 = collecting, 1 = discarding to TLAST, 2 = complete frame waiting for hold low.
    int    m_mode = 0;
    word_t m_frame[$];
    word_t m_active [N];
    bit    m_valid  = 1'b0;
    bit    m_commit = 1'b0;
    bit    m_err    = 1'b0;

    always @(posedge clk or negedge rst) begin
        bit beat;
        if (!rst) begin
            m_mode = 0;
            m_frame.delete();
            foreach (m_active[i]) m_active[i] = '0;
            m_valid  = 1'b0;
            m_commit = 1'b0;
            m_err    = 1'b0;
        end else begin
            beat     = u_axis.tvalid && (m_mode != 2);
            m_commit = 1'b0;
            m_err    = 1'b0;
            case (m_mode)
                0: if (beat) begin
                    m_frame.push_back(u_axis.tdata);
                    if (m_frame.size() == N) begin
                        if (u_axis.tlast) begin
                            m_mode = 2;
                        end else begin
                            m_err  = 1'b1;
                            m_mode = 1;
                            m_frame.delete();
                        end
                    end else if (u_axis.tlast) begin
                        m_err = 1'b1;
                        m_frame.delete();
                    end
                end
                1: if (beat && u_axis.tlast) m_mode = 0;
                default: if (!hold) begin
                    foreach (m_active[i]) m_active[i] = m_frame[i];
                    m_valid  = 1'b1;
                    m_commit = 1'b1;
                    m_frame.delete();
                    m_mode = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        int idx;
        idx = 0;
        check("tready", u_axis.tready, rst && (m_mode != 2));
        check("weights_valid", weights_valid, m_valid);
        check("commit_pulse", commit_pulse, m_commit);
        check("load_error", load_error, m_err);
        for (int i = N - 1; i >= 0; i--) begin
            if (weights[i / COLS][i % COLS] !== m_active[i]) idx = i;
        end
        check("weights", weights[idx / COLS][idx % COLS], m_active[idx]);
    end

    task automatic idle(input int n);
        u_axis.tvalid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Entered and left on a falling edge; the beat transfers on the rising edge in between.
    task automatic send(input word_t d, input bit l);
        int t;
        t = 0;
        u_axis.tvalid = 1'b1;
        u_axis.tdata  = d;
        u_axis.tlast  = l;
        while (!u_axis.tready && t <= 200) begin
            if (rand_hold) hold = 1'($urandom_range(0, 1));
            @(negedge clk);
            t++;
        end
        if (t > 200) begin
            n_checks++;
            n_err++;
            $display("FAIL send_timeout: tready low for %0d cycles, expected high", t);
        end
        @(negedge clk);
        u_axis.tvalid = 1'b0;
        if (rand_hold) hold = 1'($urandom_range(0, 1));
    endtask

    task automatic frame(input word_t base, input int len, input int last_at, input int gapmax);
        for (int i = 1; i <= len; i++) begin
            if (gapmax > 0) idle($urandom_range(0, gapmax));
            send(base + word_t'(i), i == last_at);
        end
    endtask

    initial begin
        u_axis.tvalid = 1'b0;
        u_axis.tdata  = '0;
        u_axis.tlast  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_weights_valid", weights_valid, 0);
        check("rst_tready", u_axis.tready, 0);
        check("rst_w00", weights[0][0], 0);
        rst = 1'b1;
        @(negedge clk);

        // Basic frame: commit one edge after beat 12.
        frame(0, 12, 12, 0);
        check("s1_pulse_early", commit_pulse, 0);
        @(negedge clk);
        check("s1_pulse", commit_pulse, 1);
        check("s1_w00", weights[0][0], 1);
        check("s1_w23", weights[2][3], 12);
        check("s1_valid", weights_valid, 1);
        @(negedge clk);
        check("s1_pulse_once", commit_pulse, 0);

        // Hold defers the commit.
        hold = 1'b1;
        frame(200, 12, 12, 0);
        for (int k = 0; k < 20; k++) begin
            check("s2_tready_held", u_axis.tready, 0);
            check("s2_w00_held", weights[0][0], 1);
            @(negedge clk);
        end
        hold = 1'b0;
        @(negedge clk);
        check("s2_pulse", commit_pulse, 1);
        check("s2_w00", weights[0][0], 201);

        // Early TLAST, then a good frame.
        frame(300, 5, 5, 0);
        check("s3_error", load_error, 1);
        check("s3_no_commit", weights[0][0], 201);
        frame(100, 12, 12, 0);
        @(negedge clk);
        check("s3_w10", weights[1][0], 105);

        // Overlong frame: error at word 12, rest drained.
        for (int i = 1; i <= 12; i++) send(400 + word_t'(i), 1'b0);
        check("s4_error", load_error, 1);
        send(413, 1'b0);
        send(414, 1'b1);
        idle(2);
        check("s4_kept", weights[1][0], 105);
        frame(500, 12, 12, 0);
        idle(2);
        check("s4_w00", weights[0][0], 501);

        // Randomised frames with random gaps and hold.
        rand_hold = 1'b1;
        for (int k = 0; k < 12; k++) begin
            int kind;
            kind = $urandom_range(0, 3);
            case (kind)
                0: frame(word_t'($urandom), 12, 12, 2);
                1: frame(word_t'($urandom), $urandom_range(1, 11), 0, 2) ;
                2: frame(word_t'($urandom), 15, 15, 1);
                default: frame(word_t'($urandom), 12, 12, 0);
            endcase
            if (kind == 1) send(word_t'($urandom), 1'b1);
        end
        rand_hold = 1'b0;
        hold      = 1'b0;
        idle(2);

        // Back-to-back frames A then B.
        frame(600, 12, 12, 3);
        frame(700, 12, 12, 3);
        idle(2);
        check("s5_w00", weights[0][0], 701);
        check("s5_w23", weights[2][3], 712);

        // Asynchronous reset mid-frame at word 7.
        for (int i = 1; i <= 6; i++) send(800 + word_t'(i), 1'b0);
        u_axis.tvalid = 1'b1;
        u_axis.tdata  = 807;
        u_axis.tlast  = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("s6_w00_rst", weights[0][0], 0);
        check("s6_valid_rst", weights_valid, 0);
        check("s6_tready_rst", u_axis.tready, 0);
        @(negedge clk);
        u_axis.tvalid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        frame(900, 12, 12, 2);
        idle(2);
        check("s6_w23", weights[2][3], 912);
        check("s6_valid", weights_valid, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
